store_queue_ctrl: RTL and testbench
===================================

STORE_QUEUE_CTRL -- requirements
Module: store_queue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1  store request from issue slot 0/1.
REQ-007 SHALL have ports req0_addr/req1_addr  input  AW  store address per slot.
REQ-008 SHALL have ports req0_data/req1_data  input  DW  store data per slot.
REQ-009 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle when valid&ready.
REQ-010 SHALL have port mem_req  output  1  store request to memory bus.
REQ-011 SHALL have port mem_addr  output  AW  address of queue head.
REQ-012 SHALL have port mem_data  output  DW  data of queue head.
REQ-013 SHALL have port mem_ack  input  1  bus completed the presented store.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 SHALL have ports full/empty  output  1  count==DEPTH / count==0.
REQ-016 SHALL have port busy  output  1  high while !empty or mem_req.

Function
REQ-017 SHALL accept at most one request per cycle; grant goes to one valid requester per arbitration rule (REQ-034/035).
REQ-018 SHALL drive reqN_ready = !full & grantN, combinational from current-cycle valids and registered state.
REQ-019 SHALL NOT assert ready when full, even if a pop occurs the same cycle.
REQ-020 SHALL enqueue {addr,data} at write pointer on accept; write pointer increments modulo DEPTH.
REQ-021 SHALL implement drain FSM states IDLE and ISSUE.
REQ-022 IDLE: mem_req=0; transitions to ISSUE next cycle when !empty.
REQ-023 ISSUE: mem_req=1; mem_addr/mem_data equal head entry and SHALL stay stable until mem_ack.
REQ-024 ISSUE with mem_ack: pop head (read pointer +1 mod DEPTH); stay ISSUE if entries remain after the pop, else IDLE.
REQ-025 mem_ack outside ISSUE SHALL be ignored.
REQ-026 Simultaneous accept and pop SHALL leave count unchanged; both pointers advance.
REQ-027 An entry enqueued into an empty queue SHALL see mem_req asserted no earlier than the second following edge (one-cycle IDLE->ISSUE latency).
REQ-028 Stores SHALL reach the bus in acceptance order (FIFO).
REQ-029 count/full/empty SHALL be registered-consistent, updated on the same edge as the pointers.

Reset
REQ-030 On rst high at a clock edge: pointers=0, count=0, FSM=IDLE, arbitration pointer=slot 0.
REQ-031 After reset: mem_req=0, empty=1, full=0, busy=0, count=0; mem_addr/mem_data SHALL be 0.
REQ-032 Reset mid-ISSUE SHALL drop mem_req on that edge and discard all queued stores; a later mem_ack SHALL be ignored.
REQ-033 Ready outputs SHALL be 0 while rst is high.

Configuration
REQ-034 With STORE_QUEUE_RR_EN defined: round-robin arbitration; when both valid, grant slot not last granted; last-grant register updates only on an accepted request.
REQ-035 Without STORE_QUEUE_RR_EN: fixed priority, slot 0 wins whenever req0_valid; no last-grant register.

Verification
REQ-036 Reset, then req0 addr=0x100 data=0xA5 for one cycle, mem_ack held 1 -> mem_req rises 2 edges later with 0x100/0xA5; count 1->0; busy falls after pop.
REQ-037 DEPTH=4, mem_ack=0, push 5 stores via slot 0 -> first 4 accepted, full=1, req0_ready=0 on 5th; count=4.
REQ-038 Queue full, mem_ack=1 with req1_valid=1 same cycle -> pop occurs, req1 not accepted that cycle; accepted next cycle; count 4->3->4.
REQ-039 Both slots valid continuously, 4 cycles -> with RR_EN grants 0,1,0,1; without -> 0,0,0,0.
REQ-040 Queue 3 entries, ISSUE, mem_ack delayed 5 cycles -> mem_addr/mem_data stable all 5 cycles; order preserved across pointer wrap (12 stores, DEPTH=4).
REQ-041 rst asserted during ISSUE with 2 entries, then mem_ack=1 -> mem_req=0, count=0, empty=1, no pop, no further mem_req.

Source files
------------

// File: rtl/store_queue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : store_queue_ctrl                                           |
// | Description : Two-slot store queue. Arbitrates one store per cycle into  |
// |               a DEPTH-entry FIFO and drains the head to the memory bus   |
// |               through a two-state IDLE/ISSUE handshake FSM.              |
// | Options     : STORE_QUEUE_RR_EN -- round-robin arbitration between the   |
// |               two issue slots (default: slot 0 fixed priority).          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module store_queue_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [AW-1:0]            req0_addr,
  input  logic [DW-1:0]            req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [AW-1:0]            req1_addr,
  input  logic [DW-1:0]            req1_data,
  output logic                     req1_ready,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0]    c_IDLE     = 1'b0;
  localparam logic [0:0]    c_ISSUE    = 1'b1;
  localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] c_ONE      = CW'(1);

  logic [AW-1:0] r_addr_q [DEPTH];
  logic [DW-1:0] r_data_q [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_accept0;
  logic          w_accept1;
  logic          w_accept;
  logic          w_pop;
  logic [AW-1:0] w_acc_addr;
  logic [DW-1:0] w_acc_data;

  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);

`ifdef STORE_QUEUE_RR_EN
  // Slot holding priority on the next contention; flips only on an accept.
  logic r_prio;

  // Round-robin grant: contention goes to the slot that did not win last.
  always_comb begin
    w_grant0 = req0_valid;
    w_grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant0 = ~r_prio;
      w_grant1 = r_prio;
    end
  end

  // Priority register moves away from whichever slot was just accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_accept0) begin
      r_prio <= 1'b1;
    end else if (w_accept1) begin
      r_prio <= 1'b0;
    end
  end
`else
  // Fixed priority: slot 0 always wins.
  always_comb begin
    w_grant0 = req0_valid;
    w_grant1 = req1_valid & ~req0_valid;
  end
`endif

  // Readiness never looks at a same-cycle pop, so a full queue stalls input.
  assign req0_ready = ~rst & ~w_full & w_grant0;
  assign req1_ready = ~rst & ~w_full & w_grant1;
  assign w_accept0  = req0_ready & req0_valid;
  assign w_accept1  = req1_ready & req1_valid;
  assign w_accept   = w_accept0 | w_accept1;
  assign w_acc_addr = w_accept1 ? req1_addr : req0_addr;
  assign w_acc_data = w_accept1 ? req1_data : req0_data;
  assign w_pop      = (r_state == c_ISSUE) & mem_ack;

  // Occupancy after this edge; accept and pop together cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_pop) begin
      w_count_nxt = r_count + c_ONE;
    end else if (w_pop && !w_accept) begin
      w_count_nxt = r_count - c_ONE;
    end
  end

  // Pointers and occupancy advance together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_accept) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Entry storage; contents are don't-care until written, outputs are gated.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr_q[r_wptr] <= w_acc_addr;
      r_data_q[r_wptr] <= w_acc_data;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain FSM next state: one idle cycle before issuing, stay while work remains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = c_ISSUE;
        end
      end
      c_ISSUE: begin
        if (w_pop && (w_count_nxt == '0)) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Drain FSM outputs: head is presented only in ISSUE, zero otherwise.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (r_state == c_ISSUE) begin
      mem_req  = 1'b1;
      mem_addr = r_addr_q[r_rptr];
      mem_data = r_data_q[r_rptr];
    end
  end

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;
  assign busy  = ~w_empty | mem_req;

endmodule
`default_nettype wire

// File: tb/tb_store_queue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_store_queue_ctrl                                        |
// | Description : Directed, table-driven bench for store_queue_ctrl with     |
// |               hand sequences for arbitration, stall/wrap and reset.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_store_queue_ctrl;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_addr, req1_addr, req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_data;
  logic [2:0]  count;
  logic        full, empty, busy;

  int n_checks = 0;
  int n_err    = 0;

  store_queue_ctrl #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .count(count), .full(full), .empty(empty), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v0, a0, d0, v1, a1, d1, ack;
    logic [31:0] e_r0, e_r1, e_req, e_addr, e_data, e_cnt, e_full, e_empty, e_busy;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one vector, checks pre-edge outputs, then clocks it in.
  task automatic apply(input int i, input vec_t v);
    req0_valid = v.v0[0]; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1[0]; req1_addr = v.a1; req1_data = v.d1;
    mem_ack    = v.ack[0];
    #1;
    chk($sformatf("v%0d_ready0", i), {31'b0, req0_ready}, v.e_r0);
    chk($sformatf("v%0d_ready1", i), {31'b0, req1_ready}, v.e_r1);
    chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, v.e_req);
    chk($sformatf("v%0d_mem_addr", i), mem_addr, v.e_addr);
    chk($sformatf("v%0d_mem_data", i), mem_data, v.e_data);
    chk($sformatf("v%0d_count", i), {29'b0, count}, v.e_cnt);
    chk($sformatf("v%0d_full", i), {31'b0, full}, v.e_full);
    chk($sformatf("v%0d_empty", i), {31'b0, empty}, v.e_empty);
    chk($sformatf("v%0d_busy", i), {31'b0, busy}, v.e_busy);
    tick();
  endtask

  logic [31:0] arb_exp_addr [4];
  logic        arb_exp_g0   [4];
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];

  initial begin
    //            v0  a0     d0    v1  a1     d1    ack  r0 r1 req addr   data  cnt f  e  b
    vecs[0]  = '{1, 'h100, 'hA5, 0, 0,     0,    1,   1, 0, 0,  0,     0,    0,  0, 1, 0};
    vecs[1]  = '{0, 0,     0,    0, 0,     0,    1,   0, 0, 0,  0,     0,    1,  0, 0, 1};
    vecs[2]  = '{0, 0,     0,    0, 0,     0,    1,   0, 0, 1,  'h100, 'hA5, 1,  0, 0, 1};
    vecs[3]  = '{0, 0,     0,    0, 0,     0,    1,   0, 0, 0,  0,     0,    0,  0, 1, 0};
    vecs[4]  = '{1, 'h200, 'h10, 0, 0,     0,    0,   1, 0, 0,  0,     0,    0,  0, 1, 0};
    vecs[5]  = '{1, 'h201, 'h11, 0, 0,     0,    0,   1, 0, 0,  0,     0,    1,  0, 0, 1};
    vecs[6]  = '{1, 'h202, 'h12, 0, 0,     0,    0,   1, 0, 1,  'h200, 'h10, 2,  0, 0, 1};
    vecs[7]  = '{1, 'h203, 'h13, 0, 0,     0,    0,   1, 0, 1,  'h200, 'h10, 3,  0, 0, 1};
    vecs[8]  = '{1, 'h204, 'h14, 0, 0,     0,    0,   0, 0, 1,  'h200, 'h10, 4,  1, 0, 1};
    vecs[9]  = '{0, 0,     0,    1, 'h300, 'h30, 1,   0, 0, 1,  'h200, 'h10, 4,  1, 0, 1};
    vecs[10] = '{0, 0,     0,    1, 'h300, 'h30, 0,   0, 1, 1,  'h201, 'h11, 3,  0, 0, 1};
    vecs[11] = '{0, 0,     0,    0, 0,     0,    0,   0, 0, 1,  'h201, 'h11, 4,  1, 0, 1};
    vecs[12] = '{0, 0,     0,    0, 0,     0,    1,   0, 0, 1,  'h201, 'h11, 4,  1, 0, 1};
    vecs[13] = '{0, 0,     0,    0, 0,     0,    1,   0, 0, 1,  'h202, 'h12, 3,  0, 0, 1};
    vecs[14] = '{0, 0,     0,    0, 0,     0,    1,   0, 0, 1,  'h203, 'h13, 2,  0, 0, 1};
    vecs[15] = '{0, 0,     0,    0, 0,     0,    1,   0, 0, 1,  'h300, 'h30, 1,  0, 0, 1};
    vecs[16] = '{0, 0,     0,    0, 0,     0,    1,   0, 0, 0,  0,     0,    0,  0, 1, 0};

`ifdef STORE_QUEUE_RR_EN
    arb_exp_g0   = '{1'b1, 1'b0, 1'b1, 1'b0};
    arb_exp_addr = '{32'h400, 32'h501, 32'h402, 32'h503};
`else
    arb_exp_g0   = '{1'b1, 1'b1, 1'b1, 1'b1};
    arb_exp_addr = '{32'h400, 32'h401, 32'h402, 32'h403};
`endif

    // Reset, with a request pending to confirm ready is held low.
    rst = 1'b1; mem_ack = 1'b0;
    req0_valid = 1'b1; req0_addr = 32'h1; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 32'h2; req1_data = 32'h2;
    tick();
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
    tick();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);

    // Basic drain, fill to full, full-with-pop, wrap-around drain.
    for (int i = 0; i < 17; i++) begin
      apply(i, vecs[i]);
    end

    // Both slots contend for four cycles with the bus stalled.
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_addr = 32'h400 + i; req0_data = 32'hE00 + i;
      req1_valid = 1'b1; req1_addr = 32'h500 + i; req1_data = 32'hF00 + i;
      #1;
      chk($sformatf("arb%0d_ready0", i), {31'b0, req0_ready}, {31'b0, arb_exp_g0[i]});
      chk($sformatf("arb%0d_ready1", i), {31'b0, req1_ready}, {31'b0, ~arb_exp_g0[i]});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      #1;
      chk($sformatf("arb_drain%0d_req", i), {31'b0, mem_req}, 32'd1);
      chk($sformatf("arb_drain%0d_addr", i), mem_addr, arb_exp_addr[i]);
      tick();
    end
    mem_ack = 1'b0;
    #1;
    chk("arb_drain_empty", {31'b0, empty}, 32'd1);
    tick();

    // Twelve stores through a four-entry queue, each ack delayed five cycles.
    begin
      int pushed = 0;
      int popped = 0;
      int stall  = 0;
      logic held = 1'b0;
      logic [31:0] held_addr = '0;
      logic [31:0] held_data = '0;
      for (int cyc = 0; cyc < 300 && popped < 12; cyc++) begin
        req0_valid = (pushed < 12);
        req0_addr  = 32'h600 + pushed;
        req0_data  = 32'hD000 + pushed;
        mem_ack    = mem_req && (stall == 5);
        #1;
        if (held) begin
          chk("stall_req", {31'b0, mem_req}, 32'd1);
          chk("stall_addr", mem_addr, held_addr);
          chk("stall_data", mem_data, held_data);
        end
        if (mem_req && mem_ack) begin
          if (q_addr.size() == 0) begin
            chk("order_nonempty", 32'd0, 32'd1);
          end else begin
            chk("order_addr", mem_addr, q_addr.pop_front());
            chk("order_data", mem_data, q_data.pop_front());
          end
          popped++;
          stall = 0;
          held  = 1'b0;
        end else if (mem_req) begin
          held      = 1'b1;
          held_addr = mem_addr;
          held_data = mem_data;
          stall++;
        end else begin
          held = 1'b0;
        end
        if (req0_valid && req0_ready) begin
          q_addr.push_back(req0_addr);
          q_data.push_back(req0_data);
          pushed++;
        end
        tick();
      end
      chk("wrap_pushed", pushed, 32'd12);
      chk("wrap_popped", popped, 32'd12);
    end
    req0_valid = 1'b0; mem_ack = 1'b0;
    tick();
    tick();

    // Reset while issuing with two entries queued, ack arriving afterwards.
    req0_valid = 1'b1; req0_addr = 32'h700; req0_data = 32'h70;
    tick();
    req0_addr = 32'h701; req0_data = 32'h71;
    tick();
    req0_valid = 1'b0;
    #1;
    chk("mid_issue_req", {31'b0, mem_req}, 32'd1);
    chk("mid_issue_count", {29'b0, count}, 32'd2);
    rst = 1'b1; mem_ack = 1'b1; req0_valid = 1'b1;
    #1;
    chk("mid_rst_ready0", {31'b0, req0_ready}, 32'd0);
    tick();
    rst = 1'b0; req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("post_rst%0d_req", i), {31'b0, mem_req}, 32'd0);
      chk($sformatf("post_rst%0d_count", i), {29'b0, count}, 32'd0);
      chk($sformatf("post_rst%0d_empty", i), {31'b0, empty}, 32'd1);
      chk($sformatf("post_rst%0d_addr", i), mem_addr, 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
